// File: rtl/ifu_fetch_pkg.sv
// Shared widths, memory-port payload types and PC helper for the fetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int INSTR_LEN = 32;

    // Instructions are one word; sequential fetch advances by this much.
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Request/response payloads of the instruction-memory port, shared with memory models.
    typedef struct packed {
        logic [XLEN-1:0] addr;
    } ifu_fetch_req_t;

    typedef struct packed {
        logic [INSTR_LEN-1:0] data;
    } ifu_fetch_rsp_t;

    // Next sequential PC, wrapping modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Instruction buffer: circular FIFO with push, pop, clear and an occupancy count.
// Latency: a pushed entry reaches the head one cycle later; head and count are registered.
// Backpressure: none inside; the owner never pushes when full or pops when empty.
module ifu_fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Pointer/count bookkeeping; clear wins over a same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Storage and pointers; storage is reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// Sequential instruction fetch: issues word-aligned requests and buffers in-order responses for decode.
// Latency: request accepted in N, response in N+1, instruction visible at the output in N+2.
// Backpressure: requests are credit-limited by buffer space; pipe_stall holds the head, pipe_flush redirects.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_rsp_valid,
    input  logic [INSTR_LEN-1:0] imem_rsp_data,
    input  logic                 pipe_stall,
    input  logic                 pipe_flush,
    input  logic [XLEN-1:0]      flush_pc,
    output logic [INSTR_LEN-1:0] instr,
    output logic                 instr_valid,
    output logic [XLEN-1:0]      instr_tag
);

    localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW+1:0]   DEPTH_W = (CW+2)'(FIFO_DEPTH);

    logic            run_q, run_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW+1:0]   used;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Every buffered, kept-in-flight or to-be-dropped response holds one slot of credit.
    assign used           = {2'b00, count} + {2'b00, outst_q} + {2'b00, drop_q};
    assign imem_req_valid = run_q & (used < DEPTH_W) & ~pipe_flush;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // Stale responses come back first (in-order memory), so drop them before keeping any.
    assign push        = imem_rsp_valid & (drop_q == '0) & ~pipe_flush;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid & ~pipe_stall & ~pipe_flush;
    assign instr_tag   = head_pc_q;

    ifu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INSTR_LEN)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pipe_flush),
        .push     (push),
        .push_dat (imem_rsp_data),
        .pop      (pop),
        .head_dat (instr),
        .count    (count)
    );

    // PC and credit bookkeeping; a flush turns all kept in-flight requests into drops.
    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (pipe_flush) begin
            fetch_pc_d = flush_pc;
            head_pc_d  = flush_pc;
            outst_d    = '0;
            drop_d     = drop_q + outst_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = pc_next(fetch_pc_q);
            end
            if (pop) begin
                head_pc_d = pc_next(head_pc_q);
            end
            outst_d = outst_q + CW'(req_fire) - CW'(push);
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end
    end

    // State registers; run_q keeps the request port quiet until the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

endmodule
